// File: rtl/acc_seq_pkg.sv
// Shared types and defaults for the partial-sum accumulator sequencer.
package acc_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } state_e;

   localparam int CW_DEF = 4;
   localparam int NW_DEF = 8;

endpackage

// File: rtl/wrap_counter.sv
// Counter with clear, enable and a run-time terminal value; wraps to zero
// when enabled at the terminal value.
module wrap_counter #(
   parameter int W = 4
) (
   input  logic         iCLK,
   input  logic         iRSTn,
   input  logic         iCLR,
   input  logic         iEN,
   input  logic [W-1:0] iTERM,
   output logic [W-1:0] oVAL,
   output logic         oAT_TERM
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   assign oAT_TERM = (cnt_q == iTERM);
   assign oVAL     = cnt_q;

   // next count: clear wins over enable
   always_comb begin
      cnt_d = cnt_q;
      if (iCLR) begin
         cnt_d = {W{1'b0}};
      end else if (iEN) begin
         if (oAT_TERM) begin
            cnt_d = {W{1'b0}};
         end else begin
            cnt_d = cnt_q + W'(1);
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // count register
   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn) begin
         cnt_q <= {W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/acc_seq_ctrl.sv
// Drives accumulator clear/enable/count/max so each window of iLEN+1 terms
// is summed; hands completed sums downstream and counts iNWIN windows per job.
module acc_seq_ctrl
   import acc_seq_pkg::*;
#(
   parameter int CW = CW_DEF,
   parameter int NW = NW_DEF
) (
   input  logic          iCLK,
   input  logic          iRSTn,
   input  logic          iSTART,
   input  logic          iABORT,
   input  logic [CW-1:0] iLEN,
   input  logic [NW-1:0] iNWIN,
   input  logic          iVALID,
   output logic          oREADY,
   output logic          oCLR,
   output logic          oEN,
   output logic [CW-1:0] oCNT,
   output logic [CW-1:0] oMV,
   output logic [NW-1:0] oWIN,
   output logic          oSUM_VLD,
   input  logic          iSUM_RDY,
   output logic          oBUSY,
   output logic          oDONE
);

   state_e        state_q, state_d;
   logic [CW-1:0] mv_q, mv_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [NW-1:0] nwin_q, nwin_d;
   logic          sum_vld_q, sum_vld_d;
   logic          done_q, done_d;
   logic          busy_q, busy_d;

   logic          ready;
   logic          accept;
   logic          start_ok;
   logic          cnt_clr;
   logic [CW-1:0] term_val;
   logic          term_at;
   logic [NW-1:0] win_val;
   logic          win_at;

   // Never accept while an untaken sum sits in the accumulator.
   assign ready    = (state_q == ST_RUN) && (!sum_vld_q || iSUM_RDY);
   assign accept   = iVALID && ready;
   assign start_ok = (state_q == ST_IDLE) && iSTART && !iABORT;
   assign cnt_clr  = iABORT || start_ok;

   wrap_counter #(.W(CW)) u_term_cnt (
      .iCLK     (iCLK),
      .iRSTn    (iRSTn),
      .iCLR     (cnt_clr),
      .iEN      (accept),
      .iTERM    (mv_q),
      .oVAL     (term_val),
      .oAT_TERM (term_at)
   );

   wrap_counter #(.W(NW)) u_win_cnt (
      .iCLK     (iCLK),
      .iRSTn    (iRSTn),
      .iCLR     (cnt_clr),
      .iEN      (accept && term_at),
      .iTERM    (nwin_q - NW'(1)),
      .oVAL     (win_val),
      .oAT_TERM (win_at)
   );

   // next state, latched job parameters and sum/done flags
   always_comb begin
      state_d   = state_q;
      mv_d      = mv_q;
      nwin_d    = nwin_q;
      cnt_d     = cnt_q;
      sum_vld_d = sum_vld_q;
      done_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (iSTART) begin
               mv_d   = iLEN;
               nwin_d = iNWIN;
               cnt_d  = {CW{1'b0}};
               if (iNWIN != {NW{1'b0}}) begin
                  state_d = ST_RUN;
               end else begin
                  done_d = 1'b1;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (accept && term_at && win_at) begin
               state_d = ST_FLUSH;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_FLUSH: begin
            if (iSUM_RDY) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else begin
               state_d = ST_FLUSH;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (accept) begin
         cnt_d = term_val;
      end else begin
         cnt_d = cnt_d;
      end

      // A window completing this cycle keeps the flag set even if the
      // previous sum is being taken.
      if (accept && term_at) begin
         sum_vld_d = 1'b1;
      end else if (iSUM_RDY) begin
         sum_vld_d = 1'b0;
      end else begin
         sum_vld_d = sum_vld_q;
      end

      if (iABORT) begin
         state_d   = ST_IDLE;
         mv_d      = mv_q;
         nwin_d    = nwin_q;
         cnt_d     = {CW{1'b0}};
         sum_vld_d = 1'b0;
         done_d    = 1'b0;
      end else begin
         state_d = state_d;
      end

      busy_d = (state_d != ST_IDLE);
   end

   // state and output registers
   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn) begin
         state_q   <= ST_IDLE;
         mv_q      <= {CW{1'b0}};
         nwin_q    <= {NW{1'b0}};
         cnt_q     <= {CW{1'b0}};
         sum_vld_q <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         mv_q      <= mv_d;
         nwin_q    <= nwin_d;
         cnt_q     <= cnt_d;
         sum_vld_q <= sum_vld_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
      end
   end

   assign oREADY   = ready;
   assign oCLR     = accept && (term_val == {CW{1'b0}});
   assign oEN      = accept && (term_val != {CW{1'b0}});
   assign oCNT     = cnt_q;
   assign oMV      = mv_q;
   assign oWIN     = win_val;
   assign oSUM_VLD = sum_vld_q;
   assign oBUSY    = busy_q;
   assign oDONE    = done_q;

endmodule
